// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - program counter with next-PC mode select and circular return-address stack
module pc_unit #(
    parameter int                ADDR_W    = 15,
    parameter int                RAS_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             en,
    input  logic [2:0]                       pc_sel,
    input  logic [ADDR_W-1:0]                target,
    input  logic [ADDR_W-1:0]                offset,
    input  logic                             branch_taken,
    input  logic                             err_clr,
    output logic [ADDR_W-1:0]                pc,
    output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count,
    output logic                             ras_full,
    output logic                             ras_empty,
    output logic                             ras_err
);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RAS_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(RAS_DEPTH - 1);

    localparam logic [2:0] SEL_INCR   = 3'b000;
    localparam logic [2:0] SEL_JUMP   = 3'b001;
    localparam logic [2:0] SEL_BRANCH = 3'b010;
    localparam logic [2:0] SEL_CALL   = 3'b011;
    localparam logic [2:0] SEL_RET    = 3'b100;

    logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
    // top_ptr names the next free slot; a push at full overwrites the oldest entry
    logic [PTR_W-1:0]  top_ptr;
    logic [PTR_W-1:0]  next_ptr;
    logic [PTR_W-1:0]  prev_ptr;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] pc_next;
    logic              do_push;
    logic              do_pop;
    logic              err_set;

    assign ras_full  = (ras_count == FULL_CNT);
    assign ras_empty = (ras_count == '0);
    assign next_ptr  = (top_ptr == LAST_PTR) ? '0 : top_ptr + PTR_W'(1);
    assign prev_ptr  = (top_ptr == '0) ? LAST_PTR : top_ptr - PTR_W'(1);
    assign pc_inc    = pc + ADDR_W'(1);

    assign do_push = en && (pc_sel == SEL_CALL);
    assign do_pop  = en && (pc_sel == SEL_RET) && !ras_empty;
    assign err_set = en && (((pc_sel == SEL_CALL) && ras_full) ||
                            ((pc_sel == SEL_RET) && ras_empty));

    always_comb begin
        pc_next = pc;
        if (en) begin
            case (pc_sel)
                SEL_INCR:   pc_next = pc_inc;
                SEL_JUMP:   pc_next = target;
                SEL_BRANCH: pc_next = branch_taken ? pc_inc + offset : pc_inc;
                SEL_CALL:   pc_next = target;
                SEL_RET:    pc_next = ras_empty ? pc_inc : ras_mem[prev_ptr];
                default:    pc_next = pc;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc        <= RESET_PC;
            top_ptr   <= '0;
            ras_count <= '0;
            ras_err   <= 1'b0;
        end else begin
            pc <= pc_next;
            if (do_push) begin
                top_ptr <= next_ptr;
                if (!ras_full)
                    ras_count <= ras_count + CNT_W'(1);
            end else if (do_pop) begin
                top_ptr   <= prev_ptr;
                ras_count <= ras_count - CNT_W'(1);
            end
            // a new error on the same edge as err_clr leaves the flag set
            if (err_set)
                ras_err <= 1'b1;
            else if (err_clr)
                ras_err <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            ras_mem[top_ptr] <= pc_inc;
    end
endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - scoreboard bench for pc_unit
module tb_pc_unit;
    localparam int AW    = 15;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic [2:0]    pc_sel;
    logic [AW-1:0] target;
    logic [AW-1:0] offset;
    logic          branch_taken;
    logic          err_clr;
    logic [AW-1:0] pc;
    logic [2:0]    ras_count;
    logic          ras_full;
    logic          ras_empty;
    logic          ras_err;

    pc_unit #(.ADDR_W(AW), .RAS_DEPTH(DEPTH), .RESET_PC('0)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .pc_sel(pc_sel), .target(target),
        .offset(offset), .branch_taken(branch_taken), .err_clr(err_clr),
        .pc(pc), .ras_count(ras_count), .ras_full(ras_full),
        .ras_empty(ras_empty), .ras_err(ras_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string         tag;
        logic [AW-1:0] pc;
        int            count;
        logic          err;
    } exp_t;

    exp_t          sb_q[$];
    logic [AW-1:0] m_stack[$];
    logic [AW-1:0] m_pc;
    logic          m_err;
    int            vectors = 0;
    int            miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic compare_state(input exp_t e);
        check({e.tag, ".pc"}, 32'(pc), 32'(e.pc));
        check({e.tag, ".count"}, 32'(ras_count), 32'(e.count));
        check({e.tag, ".err"}, 32'(ras_err), 32'(e.err));
        check({e.tag, ".full"}, 32'(ras_full), 32'(e.count == DEPTH));
        check({e.tag, ".empty"}, 32'(ras_empty), 32'(e.count == 0));
    endtask

    task automatic model_reset();
        m_pc  = '0;
        m_err = 1'b0;
        m_stack.delete();
    endtask

    // Drive one cycle, predict it with the model, then compare after the edge.
    task automatic step(input string tag, input logic e, input logic [2:0] sel,
                        input logic [AW-1:0] tgt, input logic [AW-1:0] off,
                        input logic tk, input logic clr);
        exp_t          x;
        logic          new_err;
        logic [AW-1:0] nxt;
        en = e; pc_sel = sel; target = tgt; offset = off; branch_taken = tk; err_clr = clr;
        new_err = 1'b0;
        nxt = m_pc;
        if (e) begin
            case (sel)
                3'd0: nxt = m_pc + 1'b1;
                3'd1: nxt = tgt;
                3'd2: nxt = tk ? m_pc + 1'b1 + off : m_pc + 1'b1;
                3'd3: begin
                    if (m_stack.size() == DEPTH) begin
                        void'(m_stack.pop_front());
                        new_err = 1'b1;
                    end
                    m_stack.push_back(m_pc + 1'b1);
                    nxt = tgt;
                end
                3'd4: begin
                    if (m_stack.size() == 0) begin
                        nxt = m_pc + 1'b1;
                        new_err = 1'b1;
                    end else begin
                        nxt = m_stack.pop_back();
                    end
                end
                default: nxt = m_pc;
            endcase
        end
        m_pc = nxt;
        if (new_err) m_err = 1'b1;
        else if (clr) m_err = 1'b0;
        x.tag = tag; x.pc = m_pc; x.count = m_stack.size(); x.err = m_err;
        sb_q.push_back(x);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) check({tag, ".sb_empty"}, 32'd1, 32'd0);
        else compare_state(sb_q.pop_front());
    endtask

    initial begin
        exp_t r;
        rst_n = 1'b0; en = 1'b0; pc_sel = 3'd0; target = '0; offset = '0;
        branch_taken = 1'b0; err_clr = 1'b0;
        model_reset();
        #22;
        r.tag = "reset"; r.pc = '0; r.count = 0; r.err = 1'b0;
        compare_state(r);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        step("stall_first", 1'b0, 3'd0, '0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step("incr", 1'b1, 3'd0, '0, '0, 1'b0, 1'b0);

        step("jump_top", 1'b1, 3'd1, 15'h7FFF, '0, 1'b0, 1'b0);
        step("incr_wrap", 1'b1, 3'd0, 15'h1234, 15'h0777, 1'b1, 1'b0);
        step("jump10", 1'b1, 3'd1, 15'h0010, '0, 1'b0, 1'b0);
        step("br_taken", 1'b1, 3'd2, 15'h5555, 15'h7FFE, 1'b1, 1'b0);
        step("jump10b", 1'b1, 3'd1, 15'h0010, '0, 1'b0, 1'b0);
        step("br_not", 1'b1, 3'd2, '0, 15'h7FFE, 1'b0, 1'b0);
        for (int s = 5; s < 8; s++) step("hold", 1'b1, 3'(s), 15'h0abc, 15'h0003, 1'b1, 1'b0);

        step("jump5", 1'b1, 3'd1, 15'h0005, '0, 1'b0, 1'b0);
        step("call100", 1'b1, 3'd3, 15'h0100, '0, 1'b0, 1'b0);
        step("ret_one", 1'b1, 3'd4, 15'h7777, '0, 1'b0, 1'b0);

        step("jump0", 1'b1, 3'd1, '0, '0, 1'b0, 1'b0);
        for (int i = 1; i <= 5; i++) step("call_n", 1'b1, 3'd3, 15'(i * 16), '0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step("ret_n", 1'b1, 3'd4, '0, '0, 1'b0, 1'b0);
        step("err_clr", 1'b1, 3'd5, '0, '0, 1'b0, 1'b1);

        step("jump20", 1'b1, 3'd1, 15'h0020, '0, 1'b0, 1'b0);
        step("ret_empty", 1'b1, 3'd4, '0, '0, 1'b0, 1'b0);
        step("clr_stalled", 1'b0, 3'd4, '0, '0, 1'b0, 1'b1);
        step("stall_call", 1'b0, 3'd3, 15'h0300, '0, 1'b0, 1'b0);
        step("set_wins", 1'b1, 3'd4, '0, '0, 1'b0, 1'b1);
        step("clr_again", 1'b1, 3'd0, '0, '0, 1'b0, 1'b1);

        step("call_a", 1'b1, 3'd3, 15'h0200, '0, 1'b0, 1'b0);
        step("call_b", 1'b1, 3'd3, 15'h0300, '0, 1'b0, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        r.tag = "async_rst"; r.pc = '0; r.count = 0; r.err = 1'b0;
        compare_state(r);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        step("ret_after_rst", 1'b1, 3'd4, '0, '0, 1'b0, 1'b0);

        for (int i = 0; i < 60; i++)
            step("rand", 1'($urandom_range(0, 7) != 0), 3'($urandom_range(0, 7)),
                 15'($urandom), 15'($urandom), 1'($urandom), 1'($urandom_range(0, 5) == 0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
